// File: rtl/pulse_gen_pkg.sv
// Shared types and constants for the pulse_gen pulse-train generator.
package pulse_gen_pkg;

  localparam int DEFAULT_WIDTH = 16;
  localparam int MIN_PERIOD    = 2;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HIGH = 2'd1,
    LOW  = 2'd2
  } state_t;

  // A legal burst needs a non-empty high phase and a non-empty low phase.
  function automatic logic cfg_legal(input logic [31:0] period, input logic [31:0] high_t);
    return (period >= 32'(MIN_PERIOD)) && (high_t >= 32'd1) && (high_t < period);
  endfunction

endpackage

// File: rtl/pulse_gen_timer.sv
// Loadable down-counter shared by the HIGH and LOW phases; expire flags a count of zero.
module pulse_gen_timer
  import pulse_gen_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic             en,
  input  logic [WIDTH-1:0] load_val,
  output logic             expire
);

  localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

  logic [WIDTH-1:0] value_r;

  // Load takes priority; otherwise count down and hold at zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      value_r <= '0;
    end else if (load) begin
      value_r <= load_val;
    end else if (en && (value_r != '0)) begin
      value_r <= value_r - ONE;
    end else begin
      value_r <= value_r;
    end
  end

  assign expire = (value_r == '0);

endmodule

// File: rtl/pulse_gen.sv
// Programmable pulse-train generator: bursts of max(MODE,1) pulses of PERIOD/HIGH_T cycles.
// Optional PULSE_GEN_CONT_EN adds a `cont` input for an endless train.
module pulse_gen
  import pulse_gen_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] PERIOD,
  input  logic [WIDTH-1:0] HIGH_T,
  input  logic [1:0]       MODE,
`ifdef PULSE_GEN_CONT_EN
  input  logic             cont,
`endif
  output logic             PULSEOUT,
  output logic             busy,
  output logic             done,
  output logic             err
);

  localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

  state_t           state_r;
  logic [WIDTH-1:0] period_r;
  logic [WIDTH-1:0] high_r;
  logic [1:0]       n_r;
  logic [1:0]       pulse_cnt_r;
  logic             pulse_r;
  logic             busy_r;
  logic             done_r;
  logic             err_r;
`ifdef PULSE_GEN_CONT_EN
  logic             cont_r;
  logic             stop_r;
`endif

  logic             legal_s;
  logic             again_s;
  logic             tmr_load_s;
  logic             tmr_en_s;
  logic [WIDTH-1:0] tmr_val_s;
  logic             tmr_expire_s;

  assign legal_s = cfg_legal(32'(PERIOD), 32'(HIGH_T));

  // Decide at the end of a LOW phase whether another pulse follows.
  always_comb begin
    again_s = 1'b0;
`ifdef PULSE_GEN_CONT_EN
    if (cont_r) begin
      again_s = cont && !stop_r;
    end else begin
      again_s = (pulse_cnt_r != n_r);
    end
`else
    again_s = (pulse_cnt_r != n_r);
`endif
  end

  // Timer reload values: each phase is loaded with its length minus one.
  always_comb begin
    tmr_load_s = 1'b0;
    tmr_en_s   = 1'b0;
    tmr_val_s  = '0;
    case (state_r)
      IDLE: begin
        if (start && legal_s) begin
          tmr_load_s = 1'b1;
          tmr_val_s  = HIGH_T - ONE;
        end else begin
          tmr_load_s = 1'b0;
        end
      end
      HIGH: begin
        if (tmr_expire_s) begin
          tmr_load_s = 1'b1;
          tmr_val_s  = period_r - high_r - ONE;
        end else begin
          tmr_en_s = 1'b1;
        end
      end
      LOW: begin
        if (tmr_expire_s && again_s) begin
          tmr_load_s = 1'b1;
          tmr_val_s  = high_r - ONE;
        end else begin
          tmr_en_s = 1'b1;
        end
      end
      default: begin
        tmr_load_s = 1'b0;
      end
    endcase
  end

  pulse_gen_timer #(.WIDTH(WIDTH)) u_timer (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (tmr_load_s),
    .en       (tmr_en_s),
    .load_val (tmr_val_s),
    .expire   (tmr_expire_s)
  );

  // Burst sequencer with registered outputs and shadowed configuration.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= IDLE;
      period_r    <= '0;
      high_r      <= '0;
      n_r         <= 2'd0;
      pulse_cnt_r <= 2'd0;
      pulse_r     <= 1'b0;
      busy_r      <= 1'b0;
      done_r      <= 1'b0;
      err_r       <= 1'b0;
`ifdef PULSE_GEN_CONT_EN
      cont_r      <= 1'b0;
      stop_r      <= 1'b0;
`endif
    end else begin
      done_r <= 1'b0;
      err_r  <= 1'b0;
      case (state_r)
        IDLE: begin
          if (start && legal_s) begin
            period_r    <= PERIOD;
            high_r      <= HIGH_T;
            n_r         <= (MODE == 2'd0) ? 2'd1 : MODE;
            pulse_cnt_r <= 2'd1;
            pulse_r     <= 1'b1;
            busy_r      <= 1'b1;
            state_r     <= HIGH;
`ifdef PULSE_GEN_CONT_EN
            cont_r      <= cont;
            stop_r      <= 1'b0;
`endif
          end else if (start) begin
            err_r <= 1'b1;
          end
        end
        HIGH: begin
          if (tmr_expire_s) begin
            pulse_r <= 1'b0;
            state_r <= LOW;
          end
        end
        LOW: begin
          if (tmr_expire_s && again_s) begin
            pulse_r <= 1'b1;
            state_r <= HIGH;
`ifdef PULSE_GEN_CONT_EN
            if (!cont_r) pulse_cnt_r <= pulse_cnt_r + 2'd1;
`else
            pulse_cnt_r <= pulse_cnt_r + 2'd1;
`endif
          end else if (tmr_expire_s) begin
            busy_r  <= 1'b0;
            done_r  <= 1'b1;
            state_r <= IDLE;
          end
        end
        default: begin
          pulse_r <= 1'b0;
          busy_r  <= 1'b0;
          state_r <= IDLE;
        end
      endcase
`ifdef PULSE_GEN_CONT_EN
      // Once cont drops during a continuous train, the train ends at the next LOW end.
      if (busy_r && cont_r && !cont) stop_r <= 1'b1;
`endif
    end
  end

  assign PULSEOUT = pulse_r;
  assign busy     = busy_r;
  assign done     = done_r;
  assign err      = err_r;

endmodule

// File: tb/tb_pulse_gen.sv
// Directed self-checking bench for pulse_gen; outputs sampled on the falling clock edge.
module tb_pulse_gen;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [15:0] period;
  logic [15:0] high_t;
  logic [1:0]  mode;
  logic        pulseout;
  logic        busy;
  logic        done;
  logic        err;
`ifdef PULSE_GEN_CONT_EN
  logic        cont;
`endif

  int n_checks;
  int n_pass;

  pulse_gen #(.WIDTH(16)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .PERIOD   (period),
    .HIGH_T   (high_t),
    .MODE     (mode),
`ifdef PULSE_GEN_CONT_EN
    .cont     (cont),
`endif
    .PULSEOUT (pulseout),
    .busy     (busy),
    .done     (done),
    .err      (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  // Called at a falling edge; start is taken at the next rising edge (cycle 0 -> cycle 1).
  // Returns at the falling edge of the done cycle, where a new start may be issued.
  task automatic burst(input int p, input int h, input int m, input bit mid_start);
    int n;
    int last;
    n = (m == 0) ? 1 : m;
    last = p * n + 1;
    period = 16'(p);
    high_t = 16'(h);
    mode   = 2'(m);
    start  = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int c = 1; c <= last; c++) begin
      check_eq($sformatf("p%0d_h%0d_m%0d pulse c%0d", p, h, m, c), 32'(pulseout),
               32'((c <= p * n) && (((c - 1) % p) < h)));
      check_eq($sformatf("p%0d_h%0d_m%0d busy c%0d", p, h, m, c), 32'(busy), 32'(c <= p * n));
      check_eq($sformatf("p%0d_h%0d_m%0d done c%0d", p, h, m, c), 32'(done), 32'(c == last));
      check_eq($sformatf("p%0d_h%0d_m%0d err c%0d", p, h, m, c), 32'(err), 32'd0);
      if (mid_start && c == 5) begin
        period = 16'd4;
        high_t = 16'd1;
        mode   = 2'd3;
        start  = 1'b1;
      end
      if (c == 6) start = 1'b0;
      if (c < last) @(negedge clk);
    end
  endtask

  task automatic reject(input int p, input int h);
    period = 16'(p);
    high_t = 16'(h);
    mode   = 2'd1;
    start  = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check_eq($sformatf("rej p%0d_h%0d err", p, h), 32'(err), 32'd1);
    check_eq($sformatf("rej p%0d_h%0d busy", p, h), 32'(busy), 32'd0);
    check_eq($sformatf("rej p%0d_h%0d pulse", p, h), 32'(pulseout), 32'd0);
    @(negedge clk);
    check_eq($sformatf("rej p%0d_h%0d err_clr", p, h), 32'(err), 32'd0);
    check_eq($sformatf("rej p%0d_h%0d busy2", p, h), 32'(busy), 32'd0);
    check_eq($sformatf("rej p%0d_h%0d pulse2", p, h), 32'(pulseout), 32'd0);
  endtask

  initial begin
    n_checks = 0;
    n_pass   = 0;
    rst_n  = 1'b0;
    start  = 1'b0;
    period = 16'd0;
    high_t = 16'd0;
    mode   = 2'd0;
`ifdef PULSE_GEN_CONT_EN
    cont   = 1'b0;
`endif
    repeat (2) @(negedge clk);
    check_eq("reset pulse", 32'(pulseout), 32'd0);
    check_eq("reset busy", 32'(busy), 32'd0);
    check_eq("reset done", 32'(done), 32'd0);
    check_eq("reset err", 32'(err), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // Two-pulse burst, then a single minimum-period pulse started in the done cycle.
    burst(10, 3, 2, 1'b0);
    burst(2, 1, 0, 1'b0);

    // Illegal configurations from IDLE.
    reject(5, 5);
    reject(10, 0);
    reject(1, 1);

    // Start during a burst is ignored; original timing holds.
    burst(10, 3, 2, 1'b1);
    @(negedge clk);
    check_eq("idle after mid-start", 32'(busy), 32'd0);

    // Reset during the second HIGH phase.
    period = 16'd10;
    high_t = 16'd3;
    mode   = 2'd2;
    start  = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (11) @(negedge clk);
    check_eq("pre-reset pulse c12", 32'(pulseout), 32'd1);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check_eq("async reset pulse", 32'(pulseout), 32'd0);
    check_eq("async reset busy", 32'(busy), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      check_eq($sformatf("post-reset pulse %0d", i), 32'(pulseout), 32'd0);
      check_eq($sformatf("post-reset busy %0d", i), 32'(busy), 32'd0);
    end
    burst(10, 3, 2, 1'b0);

`ifdef PULSE_GEN_CONT_EN
    // Continuous train: pulses start at cycles 1,5,9,13; cont drops in cycle 13.
    @(negedge clk);
    period = 16'd4;
    high_t = 16'd2;
    mode   = 2'd1;
    cont   = 1'b1;
    start  = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int c = 1; c <= 18; c++) begin
      if (c == 13) cont = 1'b0;
      check_eq($sformatf("cont pulse c%0d", c), 32'(pulseout),
               32'((c <= 16) && (((c - 1) % 4) < 2)));
      check_eq($sformatf("cont busy c%0d", c), 32'(busy), 32'(c <= 16));
      check_eq($sformatf("cont done c%0d", c), 32'(done), 32'(c == 17));
      @(negedge clk);
    end
`endif

    @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
